// File: rtl/swap_engine.sv
// Register-file swap/rotate engine: pair swap through a temp register, or rotate up by one.
// Optional rotate mode is compiled in when SWAP_ENGINE_ROTATE_EN is defined.
module swap_engine #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [IDX_W-1:0] idx_a,
    input  logic [IDX_W-1:0] idx_b,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
`ifdef SWAP_ENGINE_ROTATE_EN
        SHIFT,
`endif
        REST,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic             w_accept;
    logic             w_reject;
    logic             w_startRot;
    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_tmp;
    logic [IDX_W-1:0] r_idxA;
    logic [IDX_W-1:0] r_idxB;
    logic             r_err;

`ifdef SWAP_ENGINE_ROTATE_EN
    logic             r_op;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cntPrev;

    assign w_startRot = op;
    assign w_cntPrev  = r_cnt - IDX_W'(1);
`else
    logic w_unusedOp;

    assign w_startRot = 1'b0;
    assign w_unusedOp = op;
`endif

    // Range check without comparing against DEPTH directly, so power-of-two depths stay warning-free.
    function automatic logic idxOk(input logic [IDX_W-1:0] idx);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == IDX_W'(i)) ok = 1'b1;
        end
        return ok;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_startRot || (idxOk(idx_a) && idxOk(idx_b))) begin
                        w_accept = 1'b1;
`ifdef SWAP_ENGINE_ROTATE_EN
                        w_stateNext = op ? SHIFT : MOVE;
`else
                        w_stateNext = MOVE;
`endif
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            MOVE: w_stateNext = REST;
`ifdef SWAP_ENGINE_ROTATE_EN
            SHIFT: begin
                if (r_cnt == IDX_W'(1)) w_stateNext = REST;
            end
`endif
            REST:    w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath: host writes only land in IDLE when no operation is being accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= WIDTH'(i + 1);
            r_tmp  <= '0;
            r_idxA <= '0;
            r_idxB <= '0;
            r_err  <= 1'b0;
`ifdef SWAP_ENGINE_ROTATE_EN
            r_op   <= 1'b0;
            r_cnt  <= '0;
`endif
        end else begin
            r_err <= w_reject;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idxA <= idx_a;
                        r_idxB <= idx_b;
`ifdef SWAP_ENGINE_ROTATE_EN
                        r_op <= op;
                        if (op) begin
                            r_tmp <= r_regs[DEPTH-1];
                            r_cnt <= IDX_W'(DEPTH - 1);
                        end else begin
                            r_tmp <= r_regs[idx_a];
                        end
`else
                        r_tmp <= r_regs[idx_a];
`endif
                    end else if (wr_en && idxOk(wr_idx)) begin
                        r_regs[wr_idx] <= wr_data;
                    end
                end
                MOVE: r_regs[r_idxA] <= r_regs[r_idxB];
`ifdef SWAP_ENGINE_ROTATE_EN
                SHIFT: begin
                    r_regs[r_cnt] <= r_regs[w_cntPrev];
                    r_cnt         <= w_cntPrev;
                end
`endif
                REST: begin
`ifdef SWAP_ENGINE_ROTATE_EN
                    if (r_op) r_regs[0]      <= r_tmp;
                    else      r_regs[r_idxB] <= r_tmp;
`else
                    r_regs[r_idxB] <= r_tmp;
`endif
                end
                default: ;
            endcase
        end
    end

    // Out-of-range read indices return zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = r_regs[i];
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign err  = r_err;

endmodule

// File: tb/tb_swap_engine.sv
// Scoreboard bench for swap_engine: a DEPTH=4 and a DEPTH=3 instance share clock and reset.
module tb_swap_engine;

    localparam int EXP_DONE = 0;
    localparam int EXP_ERR  = 1;
    localparam int EXP_NONE = 2;
`ifdef SWAP_ENGINE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic isErr;
        int   cyc;
    } evt_t;

    logic       clk;
    logic       rst;
    logic       start  [2];
    logic       op     [2];
    logic [1:0] idxA   [2];
    logic [1:0] idxB   [2];
    logic       wrEn   [2];
    logic [1:0] wrIdx  [2];
    logic [5:0] wrData [2];
    logic [1:0] rdIdx  [2];
    logic [5:0] rdData [2];
    logic       busy   [2];
    logic       done   [2];
    logic       err    [2];

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    evt_t q0[$];
    evt_t q1[$];

    swap_engine #(.WIDTH(6), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .op(op[0]),
        .idx_a(idxA[0]), .idx_b(idxB[0]), .wr_en(wrEn[0]), .wr_idx(wrIdx[0]),
        .wr_data(wrData[0]), .rd_idx(rdIdx[0]), .rd_data(rdData[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    swap_engine #(.WIDTH(6), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start[1]), .op(op[1]),
        .idx_a(idxA[1]), .idx_b(idxB[1]), .wr_en(wrEn[1]), .wr_idx(wrIdx[1]),
        .wr_data(wrData[1]), .rd_idx(rdIdx[1]), .rd_data(rdData[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: any done/err pulse must match the next queued event for that instance.
    always @(negedge clk) begin
        evt_t e;
        for (int k = 0; k < 2; k++) begin
            if (done[k] || err[k]) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    checkOutput($sformatf("unexpected event inst%0d done/err", k),
                                {30'd0, done[k], err[k]}, 0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    checkOutput($sformatf("event kind inst%0d", k), {31'd0, err[k]}, {31'd0, e.isErr});
                    checkOutput($sformatf("event pulse exclusive inst%0d", k), {31'd0, done[k] & err[k]}, 0);
                    checkOutput($sformatf("event cycle inst%0d", k), cyc, e.cyc);
                end
            end
        end
    end

    task automatic applyStimulus(input int k, input logic o, input logic [1:0] a,
                                 input logic [1:0] b, input int expKind);
        evt_t e;
        int   depth;
        depth = (k == 0) ? 4 : 3;
        @(posedge clk);
        #1;
        start[k] = 1'b1;
        op[k]    = o;
        idxA[k]  = a;
        idxB[k]  = b;
        if (expKind == EXP_DONE) begin
            e.isErr = 1'b0;
            e.cyc   = cyc + ((ROT && o) ? 1 + depth : 3);
        end else begin
            e.isErr = 1'b1;
            e.cyc   = cyc + 1;
        end
        if (expKind != EXP_NONE) begin
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic checkContents(input int k, input string tag, input int e0, input int e1,
                                 input int e2, input int e3);
        int exp4 [4];
        int depth;
        exp4  = '{e0, e1, e2, e3};
        depth = (k == 0) ? 4 : 3;
        for (int i = 0; i < depth; i++) begin
            rdIdx[k] = 2'(i);
            #1;
            checkOutput($sformatf("%s inst%0d R[%0d]", tag, k, i), int'(rdData[k]), exp4[i]);
        end
    endtask

    task automatic waitIdle(input int k, input string tag);
        int n;
        n = 0;
        while (busy[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("%s inst%0d idle", tag, k), int'(busy[k]), 0);
    endtask

    task automatic writeReg(input int k, input logic [1:0] idx, input logic [5:0] data);
        @(posedge clk);
        #1;
        wrEn[k]   = 1'b1;
        wrIdx[k]  = idx;
        wrData[k] = data;
        @(posedge clk);
        #1;
        wrEn[k] = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busyCnt;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; op[k] = 1'b0; idxA[k] = '0; idxB[k] = '0;
            wrEn[k] = 1'b0; wrIdx[k] = '0; wrData[k] = '0; rdIdx[k] = '0;
        end
        #12;
        checkContents(0, "reset", 1, 2, 3, 4);
        checkOutput("reset busy", int'(busy[0]), 0);
        checkOutput("reset done", int'(done[0]), 0);
        checkOutput("reset err", int'(err[0]), 0);
        #10;
        rst = 1'b1;

        // Pair swap 0<->2
        applyStimulus(0, 1'b0, 2'd0, 2'd2, EXP_DONE);
        checkOutput("swap busy after edge0", int'(busy[0]), 1);
        waitIdle(0, "swap");
        checkContents(0, "swap", 3, 2, 1, 4);

        // Rotate (or swap 1<->3 when rotate is compiled out)
        pulseReset();
        applyStimulus(0, 1'b1, 2'd1, 2'd3, EXP_DONE);
        busyCnt = 0;
        while (busy[0] && busyCnt < 40) begin
            busyCnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("op1 busy cycles", busyCnt, ROT ? 5 : 3);
        if (ROT) checkContents(0, "rotate", 4, 1, 2, 3);
        else     checkContents(0, "op1 swap", 1, 4, 3, 2);

        // Start and write while busy are ignored
        pulseReset();
        applyStimulus(0, 1'b0, 2'd0, 2'd2, EXP_DONE);
        start[0] = 1'b1; idxA[0] = 2'd1; idxB[0] = 2'd1;
        wrEn[0] = 1'b1; wrIdx[0] = 2'd3; wrData[0] = 6'd63;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wrEn[0]  = 1'b0;
        waitIdle(0, "busy-ignore");
        checkContents(0, "busy-ignore", 3, 2, 1, 4);
        writeReg(0, 2'd3, 6'd63);
        rdIdx[0] = 2'd3;
        #1;
        checkOutput("idle write R[3]", int'(rdData[0]), 63);

        // Reset mid-operation abandons it
        pulseReset();
        applyStimulus(0, 1'b1, 2'd1, 2'd3, EXP_NONE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkContents(0, "mid-reset", 1, 2, 3, 4);
        checkOutput("mid-reset busy", int'(busy[0]), 0);
        #2;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // DEPTH=3: rejected start, then idx_a == idx_b
        applyStimulus(1, 1'b0, 2'd3, 2'd0, EXP_ERR);
        checkOutput("reject busy edge0", int'(busy[1]), 0);
        @(posedge clk);
        #1;
        checkOutput("reject busy edge1", int'(busy[1]), 0);
        checkOutput("reject err cleared", int'(err[1]), 0);
        checkContents(1, "reject", 1, 2, 3, 0);
        applyStimulus(1, 1'b0, 2'd1, 2'd1, EXP_DONE);
        waitIdle(1, "same-idx");
        checkContents(1, "same-idx", 1, 2, 3, 0);
        writeReg(1, 2'd3, 6'd45);
        checkContents(1, "oob write", 1, 2, 3, 0);
        rdIdx[1] = 2'd3;
        #1;
        checkOutput("oob read inst1", int'(rdData[1]), 0);

        repeat (6) @(posedge clk);
        #1;
        checkOutput("scoreboard inst0 drained", q0.size(), 0);
        checkOutput("scoreboard inst1 drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
